// File: rtl/fir_pkg.sv
// Shared constants and helpers for the parametrised signed FIR.
// Benches use DEFAULT_COEFS (the original 9-tap low-pass set, gain 575).
package fir_pkg;

   localparam int LATENCY = 4;

   localparam int DEFAULT_COEFS [9] = '{7, 5, 51, 135, 179, 135, 51, 5, 7};

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Exact width of a sum of n_taps full-precision products.
   function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
      return data_w + coef_w + clog2(n_taps);
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation
// of the FIR accumulator down to the output sample width.
module fir_round_sat #(
   parameter int ACC_W  = 30,
   parameter int DATA_W = 16,
   parameter int SHIFT  = 11
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] data,
   output logic                     sat
);

   // One guard bit so the rounding add can never wrap.
   localparam logic signed [ACC_W:0] HALF  = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

   logic signed [ACC_W:0] acc_ext;
   logic signed [ACC_W:0] rounded;
   logic signed [ACC_W:0] shifted;

   always_comb begin
      acc_ext = {acc[ACC_W-1], acc};
      rounded = acc_ext + HALF;
      shifted = rounded >>> SHIFT;
      data    = shifted[DATA_W-1:0];
      sat     = 1'b0;
      if (shifted > MAX_V) begin
         data = MAX_V[DATA_W-1:0];
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         data = MIN_V[DATA_W-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/fir_param.sv
// Signed direct-form FIR with run-time programmable coefficients, valid-strobed
// input, free-running 4-stage pipeline and rounded/saturated output.
module fir_param
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 10,
   parameter int N_TAPS = 9,
   parameter int SHIFT  = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [5:0]               coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_sat
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = acc_width(DATA_W, COEF_W, N_TAPS);

   logic signed [DATA_W-1:0] tap_reg   [N_TAPS];
   logic signed [DATA_W-1:0] tap_in    [N_TAPS];
   logic signed [COEF_W-1:0] coef_reg  [N_TAPS];
   logic                     coef_hit  [N_TAPS];
   logic signed [PROD_W-1:0] prod_reg  [N_TAPS];
   logic signed [PROD_W-1:0] prod_next [N_TAPS];
   logic signed [ACC_W-1:0]  sum_reg;
   logic signed [ACC_W-1:0]  sum_next;
   logic [2:0]               vld_reg;
   logic signed [DATA_W-1:0] rs_data;
   logic                     rs_sat;

   genvar gi;
   generate
      for (gi = 0; gi < N_TAPS; gi++) begin : g_tap
         if (gi == 0) begin : g_head
            assign tap_in[gi] = in_data;
         end else begin : g_body
            assign tap_in[gi] = tap_reg[gi-1];
         end
         // Addresses at or beyond N_TAPS match no tap and are dropped here.
         assign coef_hit[gi]  = coef_we && (coef_addr == 6'(gi));
         assign prod_next[gi] = PROD_W'(tap_reg[gi]) * PROD_W'(coef_reg[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_TAPS; i++) begin
            coef_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_TAPS; i++) begin
            if (coef_hit[i]) begin
               coef_reg[i] <= coef_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < N_TAPS; i++) begin
            tap_reg[i]  <= '0;
            prod_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_TAPS; i++) begin
            if (in_valid) begin
               tap_reg[i] <= tap_in[i];
            end
            prod_reg[i] <= prod_next[i];
         end
      end
   end

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         sum_next = sum_next + ACC_W'(prod_reg[i]);
      end
   end

   fir_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .SHIFT  (SHIFT)
   ) u_round_sat (
      .acc  (sum_reg),
      .data (rs_data),
      .sat  (rs_sat)
   );

   // Valid tags ride alongside the data stages and never stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_reg   <= '0;
         sum_reg   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (flush) begin
         vld_reg   <= '0;
         sum_reg   <= '0;
         out_valid <= 1'b0;
      end else begin
         vld_reg   <= {vld_reg[1:0], in_valid};
         sum_reg   <= sum_next;
         out_valid <= vld_reg[2];
         if (vld_reg[2]) begin
            out_data <= rs_data;
            out_sat  <= rs_sat;
         end
      end
   end

endmodule

// File: tb/tb_fir_param.sv
// Self-checking bench for fir_param: sample-history reference model plus
// directed impulse/DC/saturation/rounding/flush/reset cases and a random phase.
module tb_fir_param;
   import fir_pkg::*;

   // 12-bit coefficients so the 1024/1023 rounding-boundary values are representable.
   localparam int DATA_W = 16;
   localparam int COEF_W = 12;
   localparam int N_TAPS = 9;
   localparam int SHIFT  = 11;
   localparam longint MAXV = (longint'(1) <<< (DATA_W - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (DATA_W - 1));

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     flush = 1'b0;
   logic                     in_valid = 1'b0;
   logic signed [DATA_W-1:0] in_data = '0;
   logic                     coef_we = 1'b0;
   logic [5:0]               coef_addr = '0;
   logic signed [COEF_W-1:0] coef_data = '0;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_sat;

   fir_param #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .N_TAPS (N_TAPS),
      .SHIFT  (SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int data;
      bit sat;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   armed = 0;
   int   hold_d = 0;
   bit   hold_s = 0;
   int   coef_m [N_TAPS];
   int   hist   [N_TAPS];
   exp_t exp_q  [$];
   int   obs_d  [$];
   bit   obs_s  [$];
   int   obs_c  [$];
   int   imp_exp [10] = '{7, 5, 51, 135, 179, 135, 51, 5, 7, 0};

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got %0d required %0d", name, cyc, act, exp);
      end
   endtask

   // Output the filter must produce for the current sample history.
   function automatic exp_t model_out();
      exp_t   e;
      longint acc;
      longint r;
      acc = 0;
      for (int i = 0; i < N_TAPS; i++) begin
         acc += longint'(hist[i]) * longint'(coef_m[i]);
      end
      r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      e.cyc = cyc;
      e.sat = 1'b0;
      if (r > MAXV) begin
         e.data = int'(MAXV);
         e.sat  = 1'b1;
      end else if (r < MINV) begin
         e.data = int'(MINV);
         e.sat  = 1'b1;
      end else begin
         e.data = int'(r);
      end
      return e;
   endfunction

   // Reference model: reacts to the inputs seen at each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            armed = 1'b1;
            for (int i = 0; i < N_TAPS; i++) begin
               coef_m[i] = 0;
               hist[i]   = 0;
            end
            exp_q.delete();
            hold_d = 0;
            hold_s = 1'b0;
         end else begin
            if (coef_we && int'(coef_addr) < N_TAPS) begin
               coef_m[coef_addr] = int'(coef_data);
            end
            if (flush) begin
               for (int i = 0; i < N_TAPS; i++) hist[i] = 0;
               exp_q.delete();
            end else if (in_valid) begin
               for (int i = N_TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
               hist[0] = int'(in_data);
               exp_q.push_back(model_out());
            end
         end
      end
   end

   // Compare process: every falling edge, outputs against the model.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (armed) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL spurious_valid cyc=%0d got out_valid=1 required 0", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("latency", longint'(cyc - e.cyc), longint'(LATENCY - 1));
                  chk("out_data", longint'(out_data), longint'(e.data));
                  chk("out_sat", longint'(out_sat), longint'(e.sat));
                  hold_d = e.data;
                  hold_s = e.sat;
               end
               $display("out cyc=%0d data=%0d sat=%0d", cyc, out_data, out_sat);
               obs_d.push_back(int'(out_data));
               obs_s.push_back(out_sat);
               obs_c.push_back(cyc);
            end else begin
               chk("hold_data", longint'(out_data), longint'(hold_d));
               chk("hold_sat", longint'(out_sat), longint'(hold_s));
               if (exp_q.size() > 0 && (cyc - exp_q[0].cyc) > LATENCY - 1) begin
                  checks++;
                  failures++;
                  $display("FAIL missing_valid cyc=%0d got out_valid=0 required 1 (data %0d)",
                           cyc, exp_q[0].data);
                  e = exp_q.pop_front();
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
      coef_we  = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic samp(input int d);
      in_valid = 1'b1;
      in_data  = DATA_W'(d);
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wcoef(input int a, input int v);
      coef_we   = 1'b1;
      coef_addr = 6'(a);
      coef_data = COEF_W'(v);
      tick();
   endtask

   task automatic set_all(input int v);
      for (int i = 0; i < N_TAPS; i++) wcoef(i, v);
   endtask

   task automatic load_default();
      for (int i = 0; i < N_TAPS; i++) wcoef(i, DEFAULT_COEFS[i]);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
   endtask

   task automatic obs_clear();
      obs_d.delete();
      obs_s.delete();
      obs_c.delete();
   endtask

   task automatic impulse(input int amp, input int nz);
      samp(amp);
      repeat (nz) samp(0);
      idle(6);
   endtask

   task automatic chk_obs(input string name, input int idx, input int d, input bit s);
      if (idx >= obs_d.size()) begin
         checks++;
         failures++;
         $display("FAIL %s got no output #%0d (only %0d) required %0d", name, idx, obs_d.size(), d);
      end else begin
         chk(name, longint'(obs_d[idx]), longint'(d));
         chk({name, "_sat"}, longint'(obs_s[idx]), longint'(s));
      end
   endtask

   initial begin
      int seq [12];
      int run_a [$];
      int n;

      // Reset state
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'sd1234;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_sat", longint'(out_sat), 0);
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      idle(2);

      // Impulse response with out-of-range writes that must be ignored
      load_default();
      wcoef(9, 300);
      wcoef(63, -7);
      obs_clear();
      impulse(2048, 12);
      chk("imp_count", longint'(obs_d.size()), 13);
      for (int i = 0; i < 10; i++) chk_obs("impulse", i, imp_exp[i], 1'b0);

      // DC step, positive then negative
      obs_clear();
      repeat (12) samp(1000);
      repeat (12) samp(-1000);
      idle(6);
      chk_obs("dc_pos", 11, 281, 1'b0);
      chk_obs("dc_neg", 23, -281, 1'b0);

      // Gapped vs back-to-back
      for (int i = 0; i < 12; i++) seq[i] = $urandom_range(0, 6000) - 3000;
      do_flush();
      obs_clear();
      for (int i = 0; i < 12; i++) samp(seq[i]);
      idle(6);
      run_a = obs_d;
      do_flush();
      obs_clear();
      for (int i = 0; i < 12; i++) begin
         samp(seq[i]);
         idle(2);
      end
      idle(6);
      chk("b2b_count", longint'(run_a.size()), 12);
      chk("gap_count", longint'(obs_d.size()), 12);
      n = (obs_d.size() < run_a.size()) ? obs_d.size() : run_a.size();
      for (int i = 0; i < n; i++) chk("gap_match", longint'(obs_d[i]), longint'(run_a[i]));
      for (int i = 1; i < obs_c.size(); i++) chk("gap_spacing", longint'(obs_c[i] - obs_c[i-1]), 3);

      // Coefficient write coincident with a sample
      coef_we = 1'b1;
      coef_addr = 6'd0;
      coef_data = COEF_W'(100);
      samp(500);
      idle(6);
      load_default();

      // Saturation
      set_all(511);
      obs_clear();
      repeat (12) samp(32767);
      repeat (12) samp(-32768);
      idle(6);
      chk_obs("sat_pos", 11, 32767, 1'b1);
      chk_obs("sat_neg", 23, -32768, 1'b1);

      // Rounding boundary on the centre tap
      set_all(0);
      wcoef(4, 1024);
      do_flush();
      obs_clear();
      impulse(1, 8);
      chk_obs("rnd_1024", 4, 1, 1'b0);
      wcoef(4, 1023);
      obs_clear();
      impulse(1, 8);
      chk_obs("rnd_1023", 4, 0, 1'b0);
      wcoef(4, 1024);
      obs_clear();
      impulse(-1, 8);
      chk_obs("rnd_neg", 4, 0, 1'b0);

      // Flush with two samples in flight; sample presented with flush is discarded
      load_default();
      do_flush();
      obs_clear();
      samp(2048);
      samp(2048);
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 16'sd2048;
      tick();
      idle(6);
      chk("flush_drop", longint'(obs_d.size()), 0);
      impulse(2048, 8);
      chk_obs("flush_imp0", 0, 7, 1'b0);
      chk_obs("flush_imp4", 4, 179, 1'b0);

      // Random stream with coefficient writes and occasional flushes
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) in_data = DATA_W'($urandom);
         else in_data = DATA_W'($urandom_range(0, 4000) - 2000);
         if ($urandom_range(0, 9) == 0) begin
            coef_we   = 1'b1;
            coef_addr = 6'($urandom_range(0, 15));
            coef_data = COEF_W'($urandom_range(0, 1200) - 600);
         end
         if ($urandom_range(0, 49) == 0) flush = 1'b1;
         tick();
      end
      idle(6);

      // Reset mid-stream clears coefficients and drops in-flight samples
      load_default();
      obs_clear();
      samp(2048);
      samp(2048);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle(6);
      chk("rst_drop", longint'(obs_d.size()), 0);
      impulse(2048, 8);
      chk_obs("rst_imp0", 0, 0, 1'b0);
      chk_obs("rst_imp4", 4, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
